// File: rtl/pipeline_drain_if.sv
// Handshake bundle between pipeline_drain, the upstream enable-driven
// pipeline, and the downstream consumer.
//   in_valid/in_ready   producer side of the upstream pipeline input
//   pipe_en             global enable into the upstream pipeline
//   pipe_out            last-stage register of the upstream pipeline
//   out_valid/out_ready consumer handshake on the FIFO head
//   out                 FIFO head data
//   count               FIFO occupancy
// slave: the drain block. master: the surrounding environment.
interface pipeline_drain_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         pipe_en;
  logic [DW-1:0]                pipe_out;
  logic                         out_valid;
  logic                         out_ready;
  logic [DW-1:0]                out;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output in_valid, input in_ready, input pipe_en, output pipe_out,
    input out_valid, output out_ready, input out, input count
  );

  modport slave (
    input in_valid, output in_ready, output pipe_en, input pipe_out,
    output out_valid, input out_ready, output out, output count
  );
endinterface

// File: rtl/pipeline_drain.sv
// pipeline_drain: flow-control wrapper downstream of an N-stage
// enable-driven pipeline. Generates the pipeline enable, shadows stage
// validity, captures last-stage words into a DEPTH-entry first-word-fall-
// through FIFO, and presents them on a valid/ready stream.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pipeline_drain_if.slave (in_valid/in_ready, pipe_en, pipe_out,
//        out_valid/out_ready, out, count)
module pipeline_drain #(
  parameter int DW    = 32,
  parameter int N     = 8,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_drain_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  vld;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [DW-1:0] mem [DEPTH];

  logic full;
  logic en;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The enable ignores out_ready on purpose: a full FIFO stalls the
  // pipeline for the cycle of a pop, keeping out_ready off the in_ready path.
  always_comb begin
    full = (count_q == CW'(DEPTH));
    en   = ~vld[N-1] | ~full;
    push = en & vld[N-1];
    pop  = (count_q != '0) & bus.out_ready;
  end

  assign bus.pipe_en   = en;
  assign bus.in_ready  = en;
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.out       = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Bubbles shift along with data; whatever leaves stage N-1 without
      // a valid bit is simply not pushed.
      if (en) begin
        vld[0] <= bus.in_valid;
        for (int unsigned i = 1; i < N; i++) begin
          vld[i] <= vld[i-1];
        end
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pipe_out;
  end

endmodule

// File: tb/tb_pipeline_drain.sv
// Testbench for pipeline_drain: two instances (N=8/DEPTH=8 and
// N=1/DEPTH=3), each fed by a behavioural upstream register pipeline.
// Expected output order comes from a queue of accepted words.
module tb_pipeline_drain;

  localparam int DW_A = 32, N_A = 8, DEPTH_A = 8;
  localparam int DW_B = 16, N_B = 1, DEPTH_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_drain_if #(.DW(DW_A), .DEPTH(DEPTH_A)) bus_a ();
  pipeline_drain_if #(.DW(DW_B), .DEPTH(DEPTH_B)) bus_b ();

  pipeline_drain #(.DW(DW_A), .N(N_A), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  pipeline_drain #(.DW(DW_B), .N(N_B), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Upstream enable-driven pipelines (not reset, like the real ones).
  logic [DW_A-1:0] din_a;
  logic [DW_B-1:0] din_b;
  logic [DW_A-1:0] up_a [N_A];
  logic [DW_B-1:0] up_b [N_B];

  always @(posedge clk) begin
    if (bus_a.pipe_en) begin
      up_a[0] <= din_a;
      for (int i = 1; i < N_A; i++) up_a[i] <= up_a[i-1];
    end
  end
  always @(posedge clk) begin
    if (bus_b.pipe_en) begin
      up_b[0] <= din_b;
      for (int i = 1; i < N_B; i++) up_b[i] <= up_b[i-1];
    end
  end
  assign bus_a.pipe_out = up_a[N_A-1];
  assign bus_b.pipe_out = up_b[N_B-1];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int got_a     = 0;

  logic [DW_A-1:0] q_a [$];
  logic [DW_B-1:0] q_b [$];

  function automatic logic [DW_A-1:0] pop_exp_a();
    if (q_a.size() == 0) return 'x;
    return q_a.pop_front();
  endfunction

  function automatic logic [DW_B-1:0] pop_exp_b();
    if (q_b.size() == 0) return 'x;
    return q_b.pop_front();
  endfunction

  // One cycle: sample outputs at the falling edge, then apply inputs that
  // take effect at the next rising edge. Accepted words enter the model.
  task automatic drive_a(input logic iv, input logic [DW_A-1:0] d, input logic ordy,
                         output logic acc, output logic ov, output logic [DW_A-1:0] od,
                         output logic ir, output logic pe, output logic [3:0] cnt);
    @(negedge clk);
    ir  = bus_a.in_ready;
    pe  = bus_a.pipe_en;
    ov  = bus_a.out_valid;
    od  = bus_a.out;
    cnt = bus_a.count;
    bus_a.in_valid  = iv;
    din_a           = d;
    bus_a.out_ready = ordy;
    acc = iv & ir;
    if (acc) q_a.push_back(d);
  endtask

  task automatic drive_b(input logic iv, input logic [DW_B-1:0] d, input logic ordy,
                         output logic acc, output logic ov, output logic [DW_B-1:0] od,
                         output logic [1:0] cnt);
    @(negedge clk);
    ov  = bus_b.out_valid;
    od  = bus_b.out;
    cnt = bus_b.count;
    acc = iv & bus_b.in_ready;
    bus_b.in_valid  = iv;
    din_b           = d;
    bus_b.out_ready = ordy;
    if (acc) q_b.push_back(d);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus_a.out_valid); else pass_cnt++;
    total_cnt++; if (bus_a.count !== 4'd0) $display("FAIL rst_count: got %0d expected 0", bus_a.count); else pass_cnt++;
    total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus_a.in_ready); else pass_cnt++;
    total_cnt++; if (bus_a.pipe_en !== 1'b1) $display("FAIL rst_pipe_en: got %b expected 1", bus_a.pipe_en); else pass_cnt++;
    total_cnt++; if (bus_b.out_valid !== 1'b0) $display("FAIL rst_b_out_valid: got %b expected 0", bus_b.out_valid); else pass_cnt++;
    #2 rst = 1'b0;
  endtask

  task automatic test_latency();
    logic acc, ov, ir, pe;
    logic [DW_A-1:0] od, exp;
    logic [3:0] cnt;
    int sent = 0, got = 0, first_acc = -1, first_ov = -1;
    for (int c = 0; c < 24; c++) begin
      drive_a(sent < 4, DW_A'(sent + 1), 1'b1, acc, ov, od, ir, pe, cnt);
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (ov) begin
        if (first_ov < 0) first_ov = c;
        exp = pop_exp_a();
        total_cnt++; if (od !== exp) $display("FAIL lat_data: got %0h expected %0h", od, exp); else pass_cnt++;
        total_cnt++; if (c !== first_ov + got) $display("FAIL lat_gap: word %0d at cycle %0d expected %0d", got, c, first_ov + got); else pass_cnt++;
        got++;
      end
    end
    // Push at edge E0+N; first visible at the falling edge after it.
    total_cnt++; if (first_ov !== first_acc + N_A + 1) $display("FAIL lat_first: got cycle %0d expected %0d", first_ov, first_acc + N_A + 1); else pass_cnt++;
    total_cnt++; if (got !== 4) $display("FAIL lat_count: got %0d expected 4", got); else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic acc, ov, ir, pe, exp_ov;
    logic [DW_A-1:0] od, exp;
    logic [3:0] cnt;
    int got = 0, k;
    for (int c = 0; c < 32; c++) begin
      drive_a((c < 16) && (c % 2 == 0), DW_A'($urandom), 1'b1, acc, ov, od, ir, pe, cnt);
      k = c - (N_A + 1);
      exp_ov = (k >= 0) && (k < 16) && (k % 2 == 0);
      total_cnt++; if (ov !== exp_ov) $display("FAIL alt_valid: cycle %0d got %b expected %b", c, ov, exp_ov); else pass_cnt++;
      if (ov) begin
        exp = pop_exp_a();
        total_cnt++; if (od !== exp) $display("FAIL alt_data: got %0h expected %0h", od, exp); else pass_cnt++;
        got++;
      end
    end
    total_cnt++; if (got !== 8) $display("FAIL alt_count: got %0d expected 8", got); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic acc, ov, ir, pe;
    logic [DW_A-1:0] od;
    logic [3:0] cnt;
    int sent = 0;
    ir = 1'b1;
    cnt = '0;
    for (int c = 0; c < 40; c++) begin
      drive_a(1'b1, DW_A'(32'h100 + sent), 1'b0, acc, ov, od, ir, pe, cnt);
      if (acc) sent++;
    end
    total_cnt++; if (sent !== DEPTH_A + N_A) $display("FAIL fill_accepts: got %0d expected %0d", sent, DEPTH_A + N_A); else pass_cnt++;
    total_cnt++; if (ir !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", ir); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd8) $display("FAIL fill_count: got %0d expected 8", cnt); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    logic acc, ov, ir, pe;
    logic [DW_A-1:0] od, exp;
    logic [3:0] cnt;
    got_a = 0;
    drive_a(1'b0, '0, 1'b1, acc, ov, od, ir, pe, cnt);
    total_cnt++; if (pe !== 1'b0) $display("FAIL full_pe0: got %b expected 0", pe); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd8) $display("FAIL full_cnt8: got %0d expected 8", cnt); else pass_cnt++;
    exp = pop_exp_a();
    total_cnt++; if (od !== exp) $display("FAIL full_data0: got %0h expected %0h", od, exp); else pass_cnt++;
    got_a++;
    drive_a(1'b0, '0, 1'b1, acc, ov, od, ir, pe, cnt);
    total_cnt++; if (pe !== 1'b1) $display("FAIL full_pe1: got %b expected 1", pe); else pass_cnt++;
    total_cnt++; if (cnt !== 4'd7) $display("FAIL full_cnt7a: got %0d expected 7", cnt); else pass_cnt++;
    exp = pop_exp_a();
    total_cnt++; if (od !== exp) $display("FAIL full_data1: got %0h expected %0h", od, exp); else pass_cnt++;
    got_a++;
    // Simultaneous push and pop: occupancy unchanged.
    drive_a(1'b0, '0, 1'b1, acc, ov, od, ir, pe, cnt);
    total_cnt++; if (cnt !== 4'd7) $display("FAIL full_cnt7b: got %0d expected 7", cnt); else pass_cnt++;
    exp = pop_exp_a();
    total_cnt++; if (od !== exp) $display("FAIL full_data2: got %0h expected %0h", od, exp); else pass_cnt++;
    got_a++;
  endtask

  task automatic test_drain();
    logic acc, ov, ir, pe;
    logic [DW_A-1:0] od, exp;
    logic [3:0] cnt;
    for (int c = 0; c < 80 && got_a < 16; c++) begin
      drive_a(1'b0, '0, 1'b1, acc, ov, od, ir, pe, cnt);
      if (ov) begin
        exp = pop_exp_a();
        total_cnt++; if (od !== DW_A'(32'h100 + got_a) || od !== exp) $display("FAIL drain_data: got %0h expected %0h", od, 32'h100 + got_a); else pass_cnt++;
        got_a++;
      end
    end
    total_cnt++; if (got_a !== 16) $display("FAIL drain_count: got %0d expected 16", got_a); else pass_cnt++;
    total_cnt++; if (q_a.size() !== 0) $display("FAIL drain_left: got %0d expected 0", q_a.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic acc, ov, ir, pe;
    logic [DW_A-1:0] od;
    logic [3:0] cnt;
    cnt = '0;
    for (int c = 0; c < 12; c++) drive_a(1'b1, DW_A'($urandom), 1'b0, acc, ov, od, ir, pe, cnt);
    total_cnt++; if (cnt !== 4'd3) $display("FAIL pre_rst_count: got %0d expected 3", cnt); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", bus_a.out_valid); else pass_cnt++;
    total_cnt++; if (bus_a.count !== 4'd0) $display("FAIL mid_rst_count: got %0d expected 0", bus_a.count); else pass_cnt++;
    total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b expected 1", bus_a.in_ready); else pass_cnt++;
    bus_a.in_valid = 1'b0;
    q_a.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 2 * N_A + 2; c++) begin
      drive_a(1'b0, '0, 1'b1, acc, ov, od, ir, pe, cnt);
      total_cnt++; if (ov !== 1'b0) $display("FAIL post_rst_stale: cycle %0d got valid %b data %0h expected 0", c, ov, od); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic acc, ov, ordy;
    logic [DW_B-1:0] od, exp;
    logic [1:0] cnt;
    int got = 0, maxcnt = 0, errs = 0;
    ordy = 1'b0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      ordy = ($urandom % 3) != 0;
      drive_b(($urandom % 4) != 0, DW_B'($urandom), ordy, acc, ov, od, cnt);
      if (int'(cnt) > maxcnt) maxcnt = int'(cnt);
      if (ov && bus_b.out_ready) begin
        exp = pop_exp_b();
        total_cnt++;
        if (od !== exp) begin
          errs++;
          if (errs <= 10) $display("FAIL rand_data: word %0d got %0h expected %0h", got, od, exp);
        end else pass_cnt++;
        got++;
      end
    end
    total_cnt++; if (got !== 1000) $display("FAIL rand_done: got %0d words expected 1000", got); else pass_cnt++;
    total_cnt++; if (maxcnt > DEPTH_B) $display("FAIL rand_count_max: got %0d expected <= %0d", maxcnt, DEPTH_B); else pass_cnt++;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; din_a = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; din_b = '0;
    test_reset();
    test_latency();
    test_alternate();
    test_fill();
    test_full_pop();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
